lpddr2_port_arbiter: RTL and testbench

LPDDR2_PORT_ARBITER -- requirements
Module: lpddr2_port_arbiter

---
 rtl/lpddr2_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_lpddr2_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpddr2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lpddr2_port_arbiter
// Description : Two-port arbiter in front of an LPDDR2 controller's Avalon
//               slave. Port 0 is a capture write-burst source. Port 1 is a
//               video read-burst sink. Only one burst is in flight at a time.
//               The command and data outputs are decoded combinationally
//               from the FSM state, so every output is 0 in INIT.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   local_init_done         controller calibrated; gates all grants
//   req_0/addr_0/burst_0    write request (capture)
//   grant_0                 one-cycle grant pulse
//   wdata_0, wdata_ack_0    write beat data / one pulse per consumed beat
//   req_1/addr_1/burst_1    read request (video)
//   grant_1                 one-cycle grant pulse
//   rdata_1, rdata_valid_1  returned read beats (zero latency)
//   avl_*                   Avalon-MM burst master to the controller
//
// Configuration macro
//   LPDDR2_READ_PRIORITY_EN defined   : req_1 always wins (strict priority)
//   LPDDR2_READ_PRIORITY_EN undefined : round-robin; requester 1 wins first
// ============================================================================
module lpddr2_port_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               local_init_done,
  // capture write port
  input  logic               req_0,
  input  logic [ADDR_W-1:0]  addr_0,
  input  logic [BURST_W-1:0] burst_0,
  output logic               grant_0,
  input  logic [DATA_W-1:0]  wdata_0,
  output logic               wdata_ack_0,
  // video read port
  input  logic               req_1,
  input  logic [ADDR_W-1:0]  addr_1,
  input  logic [BURST_W-1:0] burst_1,
  output logic               grant_1,
  output logic [DATA_W-1:0]  rdata_1,
  output logic               rdata_valid_1,
  // Avalon-MM master
  input  logic               avl_waitrequest_n,
  output logic [ADDR_W-1:0]  avl_address,
  output logic [BURST_W-1:0] avl_burstcount,
  output logic               avl_burstbegin,
  output logic               avl_read,
  output logic               avl_write,
  output logic [DATA_W-1:0]  avl_writedata,
  input  logic               avl_readdatavalid,
  input  logic [DATA_W-1:0]  avl_readdata
);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    IDLE     = 3'd1,
    RD_CMD   = 3'd2,
    RD_WAIT  = 3'd3,
    WR_BURST = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  state_t               w_done_state;
  logic [ADDR_W-1:0]    r_addr;
  logic [BURST_W-1:0]   r_burst;
  logic [BURST_W-1:0]   r_beats;
  logic                 r_last_grant;  // 1: requester 1 was granted last
  logic                 r_first;       // first cycle of the command state
  logic                 w_pick_1;
  logic [BURST_W-1:0]   w_burst_sel;
  logic [BURST_W-1:0]   w_burst_adj;
  logic                 w_last_beat;
  logic                 w_dec;
  logic                 w_grant;

`ifdef LPDDR2_READ_PRIORITY_EN
  assign w_pick_1 = req_1;
`else
  // Requester 1 wins unless both are pending and it was served last.
  assign w_pick_1 = req_1 & (~req_0 | ~r_last_grant);
`endif

  assign w_burst_sel = w_pick_1 ? burst_1 : burst_0;
  // A zero burstcount is illegal on Avalon; treat it as a single beat.
  assign w_burst_adj = (w_burst_sel == '0) ? BURST_W'(1) : w_burst_sel;
  assign w_last_beat = (r_beats == BURST_W'(1));
  assign w_grant     = grant_0 | grant_1;

  // A burst always completes; calibration loss only redirects the exit.
  assign w_done_state = local_init_done ? IDLE : INIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= INIT;
      r_addr       <= '0;
      r_burst      <= '0;
      r_beats      <= '0;
      r_last_grant <= 1'b0;
      r_first      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_addr       <= w_pick_1 ? addr_1 : addr_0;
        r_burst      <= w_burst_adj;
        r_beats      <= w_burst_adj;
        r_last_grant <= w_pick_1;
        r_first      <= 1'b1;
      end else begin
        if (r_state == RD_CMD || r_state == WR_BURST) begin
          r_first <= 1'b0;
        end
        if (w_dec) begin
          r_beats <= r_beats - BURST_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_dec          = 1'b0;
    grant_0        = 1'b0;
    grant_1        = 1'b0;
    wdata_ack_0    = 1'b0;
    rdata_1        = '0;
    rdata_valid_1  = 1'b0;
    avl_read       = 1'b0;
    avl_write      = 1'b0;
    avl_burstbegin = 1'b0;
    avl_address    = '0;
    avl_burstcount = '0;
    avl_writedata  = '0;

    // Outputs stay quiet during the reset cycle so an aborted burst
    // cannot produce one more ack or command.
    if (!reset) begin
      case (r_state)
        INIT: begin
          if (local_init_done) begin
            w_state_nxt = IDLE;
          end
        end

        IDLE: begin
          if (!local_init_done) begin
            w_state_nxt = INIT;
          end else if (req_0 || req_1) begin
            grant_1     = w_pick_1;
            grant_0     = ~w_pick_1;
            w_state_nxt = w_pick_1 ? RD_CMD : WR_BURST;
          end
        end

        RD_CMD: begin
          avl_read       = 1'b1;
          avl_address    = r_addr;
          avl_burstcount = r_burst;
          avl_burstbegin = r_first;
          if (avl_waitrequest_n) begin
            w_state_nxt = RD_WAIT;
          end
        end

        RD_WAIT: begin
          rdata_1       = avl_readdata;
          rdata_valid_1 = avl_readdatavalid;
          if (avl_readdatavalid) begin
            w_dec = 1'b1;
            if (w_last_beat) begin
              w_state_nxt = w_done_state;
            end
          end
        end

        WR_BURST: begin
          avl_write      = 1'b1;
          avl_address    = r_addr;
          avl_burstcount = r_burst;
          avl_writedata  = wdata_0;
          avl_burstbegin = r_first;
          if (avl_waitrequest_n) begin
            wdata_ack_0 = 1'b1;
            w_dec       = 1'b1;
            if (w_last_beat) begin
              w_state_nxt = w_done_state;
            end
          end
        end

        default: w_state_nxt = INIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lpddr2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpddr2_port_arbiter
// Description : Directed self-checking bench for lpddr2_port_arbiter.
//               Checks reset state, read and write bursts, arbitration order,
//               zero burstcount, calibration loss and a mid-burst reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpddr2_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        local_init_done;
  logic        req_0, req_1;
  logic [26:0] addr_0, addr_1;
  logic [7:0]  burst_0, burst_1;
  logic        grant_0, grant_1;
  logic [31:0] wdata_0;
  logic        wdata_ack_0;
  logic [31:0] rdata_1;
  logic        rdata_valid_1;
  logic        avl_waitrequest_n;
  logic [26:0] avl_address;
  logic [7:0]  avl_burstcount;
  logic        avl_burstbegin, avl_read, avl_write;
  logic [31:0] avl_writedata;
  logic        avl_readdatavalid;
  logic [31:0] avl_readdata;

  int vectors    = 0;
  int miscompares = 0;

  lpddr2_port_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .local_init_done   (local_init_done),
    .req_0             (req_0),
    .addr_0            (addr_0),
    .burst_0           (burst_0),
    .grant_0           (grant_0),
    .wdata_0           (wdata_0),
    .wdata_ack_0       (wdata_ack_0),
    .req_1             (req_1),
    .addr_1            (addr_1),
    .burst_1           (burst_1),
    .grant_1           (grant_1),
    .rdata_1           (rdata_1),
    .rdata_valid_1     (rdata_valid_1),
    .avl_waitrequest_n (avl_waitrequest_n),
    .avl_address       (avl_address),
    .avl_burstcount    (avl_burstcount),
    .avl_burstbegin    (avl_burstbegin),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_writedata     (avl_writedata),
    .avl_readdatavalid (avl_readdatavalid),
    .avl_readdata      (avl_readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are checked
  // one more unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rv_count;
    int  acks;
    int  ngrant;
    logic order [8];
    logic exp_order [8];

    reset = 1'b1; local_init_done = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0;
    addr_0 = '0; addr_1 = '0; burst_0 = '0; burst_1 = '0; wdata_0 = '0;
    avl_waitrequest_n = 1'b0; avl_readdatavalid = 1'b0; avl_readdata = '0;
    for (int k = 0; k < 8; k++) order[k] = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_read",    64'(avl_read),       64'h0);
    check("rst_write",   64'(avl_write),      64'h0);
    check("rst_addr",    64'(avl_address),    64'h0);
    check("rst_bcount",  64'(avl_burstcount), 64'h0);
    check("rst_bbegin",  64'(avl_burstbegin), 64'h0);
    check("rst_rvalid",  64'(rdata_valid_1),  64'h0);

    // ---------------- INIT: no grants ----------------
    req_1 = 1'b1; addr_1 = 27'h100; burst_1 = 8'd4;
    #1;
    check("init_no_grant", 64'(grant_1), 64'h0);
    tick();
    local_init_done = 1'b1;
    #1;
    check("init_exit_no_grant", 64'(grant_1), 64'h0);

    // ---------------- 4-beat read with 2 wait cycles ----------------
    tick();
    #1;
    check("rd_grant1", 64'(grant_1), 64'h1);
    check("rd_grant0", 64'(grant_0), 64'h0);
    tick();
    req_1 = 1'b0; avl_waitrequest_n = 1'b0;
    #1;
    check("rd_cmd1_read",   64'(avl_read),       64'h1);
    check("rd_cmd1_bbegin", 64'(avl_burstbegin), 64'h1);
    check("rd_cmd1_addr",   64'(avl_address),    64'h100);
    check("rd_cmd1_bcount", 64'(avl_burstcount), 64'h4);
    tick();
    #1;
    check("rd_cmd2_read",   64'(avl_read),       64'h1);
    check("rd_cmd2_bbegin", 64'(avl_burstbegin), 64'h0);
    tick();
    avl_waitrequest_n = 1'b1;
    #1;
    check("rd_cmd3_read",   64'(avl_read),       64'h1);
    check("rd_cmd3_bbegin", 64'(avl_burstbegin), 64'h0);
    check("rd_cmd3_addr",   64'(avl_address),    64'h100);
    tick();
    avl_waitrequest_n = 1'b0;
    check("rd_wait_read_low", 64'(avl_read), 64'h0);
    rv_count = 0;
    // beats returned on steps 0,2,3,4; step 1 is a gap
    for (int i = 0; i < 5; i++) begin
      avl_readdatavalid = (i != 1);
      avl_readdata      = 32'hC0DE_0000 + 32'(i);
      #1;
      check("rd_beat_valid", 64'(rdata_valid_1), 64'(i != 1));
      if (rdata_valid_1) begin
        rv_count++;
        check("rd_beat_data", 64'(rdata_1), 64'(32'hC0DE_0000 + 32'(i)));
      end
      tick();
    end
    avl_readdatavalid = 1'b0;
    check("rd_beat_count", 64'(rv_count), 64'd4);

    // ---------------- IDLE lasts one cycle: write granted now ----------------
    req_0 = 1'b1; addr_0 = 27'h2A5A; burst_0 = 8'd8;
    #1;
    check("wr_grant0", 64'(grant_0), 64'h1);
    check("wr_grant1", 64'(grant_1), 64'h0);

    // ---------------- 8-beat write, waitrequest_n toggling ----------------
    tick();
    req_0 = 1'b0;
    acks = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      avl_waitrequest_n = (cyc % 2 == 0);
      wdata_0 = 32'hA000_0000 + 32'(acks);
      #1;
      check("wr_write",  64'(avl_write),      64'h1);
      check("wr_addr",   64'(avl_address),    64'h2A5A);
      check("wr_bcount", 64'(avl_burstcount), 64'h8);
      check("wr_wdata",  64'(avl_writedata),  64'(32'hA000_0000 + 32'(acks)));
      check("wr_bbegin", 64'(avl_burstbegin), 64'(cyc == 0));
      check("wr_ack",    64'(wdata_ack_0),    64'(cyc % 2 == 0));
      if (wdata_ack_0) acks++;
      tick();
    end
    avl_waitrequest_n = 1'b1;
    #1;
    check("wr_done_write", 64'(avl_write),   64'h0);
    check("wr_done_ack",   64'(wdata_ack_0), 64'h0);
    check("wr_ack_count",  64'(acks),        64'd8);

    // ---------------- both requesting: arbitration order ----------------
    req_0 = 1'b1; req_1 = 1'b1; burst_0 = 8'd1; burst_1 = 8'd1;
    addr_0 = 27'h10; addr_1 = 27'h20;
    avl_waitrequest_n = 1'b1; avl_readdatavalid = 1'b1;
    ngrant = 0;
    for (int cyc = 0; cyc < 40 && ngrant < 8; cyc++) begin
      #1;
      if (grant_0 || grant_1) begin
        order[ngrant] = grant_1;
        ngrant++;
      end
      tick();
    end
    req_0 = 1'b0; req_1 = 1'b0;
    check("arb_grant_count", 64'(ngrant), 64'd8);
    for (int k = 0; k < 8; k++) begin
`ifdef LPDDR2_READ_PRIORITY_EN
      exp_order[k] = 1'b1;
`else
      exp_order[k] = (k % 2 == 0);
`endif
      check("arb_order", 64'(order[k]), 64'(exp_order[k]));
    end
    tick(); tick(); tick();
    avl_readdatavalid = 1'b0;

    // ---------------- burst_1 = 0 treated as 1 ----------------
    req_1 = 1'b1; addr_1 = 27'h3FF; burst_1 = 8'd0;
    #1;
    check("z_grant1", 64'(grant_1), 64'h1);
    tick();
    req_1 = 1'b0;
    #1;
    check("z_read",   64'(avl_read),       64'h1);
    check("z_bcount", 64'(avl_burstcount), 64'h1);
    tick();
    avl_readdatavalid = 1'b1; avl_readdata = 32'hDEAD_BEEF;
    #1;
    check("z_rvalid", 64'(rdata_valid_1), 64'h1);
    check("z_rdata",  64'(rdata_1),       64'hDEAD_BEEF);
    tick();
    avl_readdata = 32'h1234_5678;
    #1;
    check("stray_rvalid", 64'(rdata_valid_1), 64'h0);
    check("stray_rdata",  64'(rdata_1),       64'h0);

    // ---------------- calibration lost during a read ----------------
    avl_readdatavalid = 1'b0;
    req_1 = 1'b1; addr_1 = 27'h55; burst_1 = 8'd2;
    #1;
    check("cal_grant1", 64'(grant_1), 64'h1);
    tick();
    req_1 = 1'b0; local_init_done = 1'b0;
    #1;
    check("cal_read", 64'(avl_read), 64'h1);
    tick();
    avl_readdatavalid = 1'b1; avl_readdata = 32'h1111;
    #1;
    check("cal_beat1", 64'(rdata_valid_1), 64'h1);
    tick();
    avl_readdatavalid = 1'b0;
    #1;
    check("cal_gap", 64'(rdata_valid_1), 64'h0);
    tick();
    avl_readdatavalid = 1'b1; avl_readdata = 32'h2222;
    #1;
    check("cal_beat2",  64'(rdata_valid_1), 64'h1);
    check("cal_rdata2", 64'(rdata_1),       64'h2222);
    tick();
    avl_readdatavalid = 1'b0;
    req_0 = 1'b1; req_1 = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      check("cal_no_grant", 64'(grant_0 | grant_1), 64'h0);
      tick();
    end
    local_init_done = 1'b1;
    #1;
    check("cal_init_exit_no_grant", 64'(grant_0 | grant_1), 64'h0);
    tick();
    req_1 = 1'b0; addr_0 = 27'h777; burst_0 = 8'd8;
    #1;
    check("cal_regrant0", 64'(grant_0), 64'h1);

    // ---------------- reset in the third beat of an 8-beat write ----------------
    tick();
    req_0 = 1'b0; avl_waitrequest_n = 1'b1; wdata_0 = 32'h1;
    #1;
    check("rstw_ack1", 64'(wdata_ack_0), 64'h1);
    tick();
    wdata_0 = 32'h2;
    #1;
    check("rstw_ack2", 64'(wdata_ack_0), 64'h1);
    tick();
    wdata_0 = 32'h3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    avl_readdatavalid = 1'b1; avl_readdata = 32'hFFFF_0000;
    req_0 = 1'b1;
    #1;
    check("rstw_ack",    64'(wdata_ack_0),    64'h0);
    check("rstw_write",  64'(avl_write),      64'h0);
    check("rstw_read",   64'(avl_read),       64'h0);
    check("rstw_addr",   64'(avl_address),    64'h0);
    check("rstw_bcount", 64'(avl_burstcount), 64'h0);
    check("rstw_wdata",  64'(avl_writedata),  64'h0);
    check("rstw_bbegin", 64'(avl_burstbegin), 64'h0);
    check("rstw_rvalid", 64'(rdata_valid_1),  64'h0);
    check("rstw_rdata",  64'(rdata_1),        64'h0);
    check("rstw_init_no_grant", 64'(grant_0 | grant_1), 64'h0);
    tick();
    #1;
    check("rstw_idle_grant0", 64'(grant_0), 64'h1);
    check("rstw_idle_rvalid", 64'(rdata_valid_1), 64'h0);
    tick();
    req_0 = 1'b0;
    #1;
    check("rstw_wr_rvalid", 64'(rdata_valid_1), 64'h0);
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
